// File: rtl/axi_pkg.sv
// axi_pkg: AXI response/burst encodings and AR FSM state shared by the streaming read blocks
package axi_pkg;
  localparam logic [1:0] RSP_OKAY   = 2'b00;
  localparam logic [1:0] RSP_EXOKAY = 2'b01;
  localparam logic [1:0] RSP_SLVERR = 2'b10;
  localparam logic [1:0] RSP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  typedef enum logic {AR_IDLE, AR_REQ} ar_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign empty    = count == '0;
  assign full     = count == CW'(DEPTH);
  assign pop_data = mem[rd_ptr];
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == AW'(DEPTH-1) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr == AW'(DEPTH-1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset; empty gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/axi_stream_read_master.sv
// axi_stream_read_master: credit-gated FIXED-burst AXI reader re-emitting R beats as a stream
module axi_stream_read_master
  import axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    RUSER_WIDTH = 32,
  parameter int                    ID_WIDTH    = 1,
  parameter logic [ADDR_WIDTH-1:0] ADDRESS     = '0,
  parameter logic [ID_WIDTH-1:0]   ARID        = '0,
  parameter int                    BURST_LEN   = 16,
  parameter int                    FIFO_DEPTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   error_clear,
  output logic                   resp_error,
  output logic                   proto_error,
  output logic                   busy,
  input  logic                   output_ready,
  output logic                   output_valid,
  output logic [DATA_WIDTH-1:0]  output_data,
  output logic [RUSER_WIDTH-1:0] output_data_user,
  output logic                   output_last,
  input  logic                   m_axi_arready,
  output logic                   m_axi_arvalid,
  output logic [ADDR_WIDTH-1:0]  m_axi_araddr,
  output logic [ID_WIDTH-1:0]    m_axi_arid,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  output logic                   m_axi_rready,
  input  logic                   m_axi_rvalid,
  input  logic [DATA_WIDTH-1:0]  m_axi_rdata,
  input  logic [RUSER_WIDTH-1:0] m_axi_ruser,
  input  logic [ID_WIDTH-1:0]    m_axi_rid,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rlast
);
  localparam int PW = $clog2(FIFO_DEPTH+1);
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam int FW = DATA_WIDTH + RUSER_WIDTH + 1;
  ar_state_t state, state_next;
  logic [PW-1:0] pending, fifo_count;
  logic [PW:0] credit;
  logic [BW-1:0] beat_cnt;
  logic reserve, beat, exp_last, bad_resp, bad_proto, fifo_empty, fifo_full;
  assign m_axi_araddr  = ADDRESS;
  assign m_axi_arid    = ARID;
  assign m_axi_arlen   = 8'(BURST_LEN-1);
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH/8));
  assign m_axi_arburst = BURST_FIXED;
  assign m_axi_rready  = ~fifo_full;
  assign credit    = (PW+1)'(FIFO_DEPTH) - (PW+1)'(fifo_count) - (PW+1)'(pending);
  assign reserve   = state == AR_IDLE && enable && credit >= (PW+1)'(BURST_LEN);
  assign beat      = m_axi_rvalid && m_axi_rready;
  assign exp_last  = beat_cnt == BW'(BURST_LEN-1);
  assign bad_resp  = m_axi_rresp != RSP_OKAY;
  assign bad_proto = m_axi_rid != ARID || m_axi_rlast != exp_last;
  assign output_valid = ~fifo_empty;
  assign busy = m_axi_arvalid || pending != '0;
  // AR state register
  always_ff @(posedge clk) begin
    if (reset) state <= AR_IDLE;
    else state <= state_next;
  end
  // AR next state: request once credit is reserved, hold until handshake
  always_comb begin
    state_next = state == AR_IDLE ? (reserve ? AR_REQ : AR_IDLE) : (m_axi_arready ? AR_IDLE : AR_REQ);
  end
  // AR outputs
  always_comb begin
    m_axi_arvalid = state == AR_REQ;
  end
  // outstanding beats, burst position and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= '0;
      beat_cnt    <= '0;
      resp_error  <= 1'b0;
      proto_error <= 1'b0;
    end else begin
      pending     <= pending + (reserve ? PW'(BURST_LEN) : '0) - PW'(beat);
      beat_cnt    <= beat ? (exp_last ? '0 : beat_cnt + 1'b1) : beat_cnt;
      resp_error  <= beat && bad_resp ? 1'b1 : error_clear ? 1'b0 : resp_error;
      proto_error <= beat && !bad_resp && bad_proto ? 1'b1 : error_clear ? 1'b0 : proto_error;
    end
  end
  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (beat && !bad_resp),
    .push_data ({m_axi_rdata, m_axi_ruser, exp_last}),
    .pop       (output_valid && output_ready),
    .pop_data  ({output_data, output_data_user, output_last}),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_axi_stream_read_master.sv
// tb_axi_stream_read_master: directed table-driven bench with a scripted R/AR slave
module tb_axi_stream_read_master;
  logic clk = 0, reset = 1, enable = 0, error_clear = 0, output_ready = 0;
  logic resp_error, proto_error, busy, output_valid, output_last;
  logic [31:0] output_data, output_data_user;
  logic m_axi_arready = 0, m_axi_arvalid, m_axi_rready;
  logic [31:0] m_axi_araddr;
  logic [0:0] m_axi_arid;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst;
  logic m_axi_rvalid = 0, m_axi_rlast = 0;
  logic [31:0] m_axi_rdata = 0, m_axi_ruser = 0;
  logic [0:0] m_axi_rid = 0;
  logic [1:0] m_axi_rresp = 0;
  int errors = 0, checks = 0, viol = 0;
  logic [64:0] rxq[$];

  axi_stream_read_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RUSER_WIDTH(32), .ID_WIDTH(1),
    .ADDRESS(32'h0000_1000), .ARID(1'b0), .BURST_LEN(4), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .error_clear(error_clear),
    .resp_error(resp_error), .proto_error(proto_error), .busy(busy),
    .output_ready(output_ready), .output_valid(output_valid), .output_data(output_data),
    .output_data_user(output_data_user), .output_last(output_last),
    .m_axi_arready(m_axi_arready), .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_rready(m_axi_rready), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rdata(m_axi_rdata), .m_axi_ruser(m_axi_ruser), .m_axi_rid(m_axi_rid),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && output_valid && output_ready) rxq.push_back({output_last, output_data_user, output_data});
    if (m_axi_rvalid && !m_axi_rready) viol++;
  end

  typedef struct {
    logic [31:0] base;
    int bad;
    int lastb;
    logic bad_id;
    int clr;
    logic exp_resp;
    logic exp_proto;
    int exp_n;
  } rec_t;

  function automatic logic [31:0] usr(input logic [31:0] d);
    return d ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [64:0] ob(input logic [31:0] d, input logic l);
    return {l, usr(d), d};
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    m_axi_rvalid = 0;
    m_axi_arready = 0;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic wait_ar();
    int n = 0;
    while (!m_axi_arvalid && n < 50) begin
      tick();
      n++;
    end
    chk("ar_timeout", 65'(m_axi_arvalid), 65'd1);
    chk("ar_fields", {m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst},
        {32'h0000_1000, 1'b0, 8'd3, 3'd2, 2'd0});
  endtask

  task automatic ar_hs();
    m_axi_arready = 1;
    tick();
    m_axi_arready = 0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [1:0] resp, input logic last, input logic id);
    m_axi_rvalid = 1;
    m_axi_rdata = d;
    m_axi_ruser = usr(d);
    m_axi_rresp = resp;
    m_axi_rlast = last;
    m_axi_rid = id;
    tick();
    m_axi_rvalid = 0;
  endtask

  rec_t tbl[6];

  initial begin
    int s0, j, cnt;
    tbl[0] = '{32'h11, -1, 3, 1'b0, -1, 1'b0, 1'b0, 4};
    tbl[1] = '{32'h21,  1, 3, 1'b0,  1, 1'b1, 1'b0, 3};
    tbl[2] = '{32'h31, -1, 1, 1'b0, -1, 1'b0, 1'b1, 4};
    tbl[3] = '{32'h41, -1, 3, 1'b1, -1, 1'b0, 1'b1, 4};
    tbl[4] = '{32'h51,  3, 3, 1'b0, -1, 1'b1, 1'b0, 3};
    tbl[5] = '{32'h61, -1, 3, 1'b0,  0, 1'b0, 1'b0, 4};
    tick();
    chk("reset_state", {61'd0, m_axi_arvalid, output_valid, busy, resp_error | proto_error}, 65'd0);
    reset = 0;
    enable = 1;
    output_ready = 1;
    for (int r = 0; r < 6; r++) begin
      s0 = rxq.size();
      wait_ar();
      ar_hs();
      for (int i = 0; i < 4; i++) begin
        error_clear = (i == tbl[r].clr);
        send_beat(tbl[r].base + 32'(i), i == tbl[r].bad ? 2'b10 : 2'b00, i == tbl[r].lastb, tbl[r].bad_id);
        error_clear = 0;
      end
      repeat (3) tick();
      chk($sformatf("rec%0d_count", r), 65'(rxq.size() - s0), 65'(tbl[r].exp_n));
      j = 0;
      for (int i = 0; i < 4; i++) begin
        if (i != tbl[r].bad) begin
          if (s0 + j < rxq.size())
            chk($sformatf("rec%0d_beat%0d", r, i), rxq[s0+j], ob(tbl[r].base + 32'(i), i == 3));
          j++;
        end
      end
      chk($sformatf("rec%0d_flags", r), {63'd0, resp_error, proto_error}, {63'd0, tbl[r].exp_resp, tbl[r].exp_proto});
      error_clear = 1;
      tick();
      error_clear = 0;
      chk($sformatf("rec%0d_cleared", r), {63'd0, resp_error, proto_error}, 65'd0);
    end

    // consumer stalled: two bursts fill the buffer, then AR waits for four pops
    do_reset();
    enable = 1;
    output_ready = 0;
    s0 = rxq.size();
    for (int b = 0; b < 2; b++) begin
      wait_ar();
      ar_hs();
      for (int i = 0; i < 4; i++) send_beat(32'h71 + 32'(4*b + i), 2'b00, i == 3, 1'b0);
    end
    cnt = 0;
    repeat (8) begin
      tick();
      if (m_axi_arvalid) cnt++;
    end
    chk("stall_no_ar", 65'(cnt), 65'd0);
    chk("stall_buffered", {63'd0, output_valid, m_axi_rready}, {63'd0, 1'b1, 1'b0});
    chk("stall_no_pop", 65'(rxq.size() - s0), 65'd0);
    output_ready = 1;
    repeat (4) tick();
    output_ready = 0;
    chk("stall_ar_not_yet", 65'(m_axi_arvalid), 65'd0);
    tick();
    chk("stall_ar_after_pops", 65'(m_axi_arvalid), 65'd1);
    chk("stall_popped", 65'(rxq.size() - s0), 65'd4);
    for (int i = 0; i < 4; i++)
      if (s0 + i < rxq.size()) chk($sformatf("stall_beat%0d", i), rxq[s0+i], ob(32'h71 + 32'(i), i == 3));
    wait_ar();
    ar_hs();
    for (int i = 0; i < 4; i++) send_beat(32'h79 + 32'(i), 2'b00, i == 3, 1'b0);
    output_ready = 1;
    repeat (12) tick();
    chk("stall_total", 65'(rxq.size() - s0), 65'd12);
    if (s0 + 11 < rxq.size()) begin
      chk("stall_beat7", rxq[s0+7], ob(32'h78, 1'b1));
      chk("stall_beat11", rxq[s0+11], ob(32'h7C, 1'b1));
    end

    // enable dropped while AR is waiting for arready
    do_reset();
    enable = 1;
    output_ready = 1;
    wait_ar();
    enable = 0;
    cnt = 0;
    repeat (5) begin
      tick();
      if (m_axi_arvalid && m_axi_arlen == 8'd3 && m_axi_araddr == 32'h1000 && m_axi_arburst == 2'd0) cnt++;
    end
    chk("hold_ar_stable", 65'(cnt), 65'd5);
    ar_hs();
    for (int i = 0; i < 3; i++) send_beat(32'h81 + 32'(i), 2'b00, 1'b0, 1'b0);
    chk("busy_before_last", 65'(busy), 65'd1);
    send_beat(32'h84, 2'b00, 1'b1, 1'b0);
    chk("busy_after_last", 65'(busy), 65'd0);
    cnt = 0;
    repeat (10) begin
      tick();
      if (m_axi_arvalid) cnt++;
    end
    chk("disabled_no_ar", 65'(cnt), 65'd0);

    // reset in the middle of a burst discards everything
    do_reset();
    enable = 1;
    output_ready = 0;
    wait_ar();
    ar_hs();
    send_beat(32'h91, 2'b00, 1'b0, 1'b1);
    send_beat(32'h92, 2'b00, 1'b0, 1'b0);
    chk("pre_reset", {62'd0, proto_error, busy, output_valid}, {62'd0, 3'b111});
    reset = 1;
    tick();
    chk("mid_reset", {61'd0, output_valid, m_axi_arvalid, busy, resp_error | proto_error}, 65'd0);
    reset = 0;
    enable = 0;
    tick();

    chk("rready_never_low_with_rvalid", 65'(viol), 65'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
